fetch_decode_stage: RTL and testbench

PC register, next-PC logic and F/D pipeline register for the five-stage MIPS core. Fetches from the combinational instruction ROM, delivers the D-stage instruction (the one the hazard/stall controller inspects as its D-stage input), and honours that controller's stall by freezing F and D and requesting a bubble into E. Resolves beq/j/jal/jr in D with one architectural delay slot, so no fetched instruction is ever squashed.

---
 rtl/fetch_decode_stage_if.sv | 28 ++
 rtl/fetch_decode_stage.sv | 83 ++++++++
 tb/tb_fetch_decode_stage.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_stage_if.sv
// Fetch/decode stage bus: hazard-controller inputs, instruction ROM port and D-stage outputs.
interface fetch_decode_stage_if #(
  parameter int unsigned IM_AW = 10
);
  logic             stall;
  logic             br_eq;
  logic [31:0]      jr_target;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  logic [31:0]      pc_f;
  logic [31:0]      instr_d;
  logic [31:0]      pc_d;
  logic [31:0]      pc8_d;
  logic             valid_d;
  logic             bubble_e;
  logic [31:0]      stall_cnt;
  logic [31:0]      fetch_cnt;

  modport master (
    output stall, br_eq, jr_target, im_rdata,
    input  im_addr, pc_f, instr_d, pc_d, pc8_d, valid_d, bubble_e, stall_cnt, fetch_cnt
  );

  modport slave (
    input  stall, br_eq, jr_target, im_rdata,
    output im_addr, pc_f, instr_d, pc_d, pc8_d, valid_d, bubble_e, stall_cnt, fetch_cnt
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// PC register, next-PC selection and F/D pipeline register for the five-stage MIPS core.
// Control transfers resolve in D with one delay slot; stall freezes F and D and bubbles E.
module fetch_decode_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_AW    = 10
) (
  input logic                 clk,
  input logic                 reset,
  fetch_decode_stage_if.slave bus
);
  localparam logic [31:0] WIN_BYTES = 32'd4 << IM_AW;

  typedef enum logic [1:0] {CF_SEQ, CF_BEQ, CF_JUMP, CF_JR} cf_e;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_d_q;
  logic        valid_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] fetch_cnt_q;

  logic [31:0] pc_off;
  logic        in_window;
  logic [31:0] fetch_word;
  logic [31:0] br_off;
  logic [31:0] npc;
  cf_e         cf;

  assign pc_off     = pc_q - PC_RESET;
  assign in_window  = pc_off < WIN_BYTES;
  assign fetch_word = in_window ? bus.im_rdata : '0;
  assign br_off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Cleared instr_d (after reset) has opcode/funct 0 and falls through to sequential.
  always_comb begin
    cf = CF_SEQ;
    if (instr_q[31:26] == 6'b000100)
      cf = CF_BEQ;
    else if (instr_q[31:26] == 6'b000010 || instr_q[31:26] == 6'b000011)
      cf = CF_JUMP;
    else if (instr_q[31:26] == 6'b000000 && instr_q[5:0] == 6'b001000)
      cf = CF_JR;
  end

  always_comb begin
    npc = pc_q + 32'd4;
    case (cf)
      CF_BEQ:  if (bus.br_eq) npc = pc_d_q + 32'd4 + br_off;
      CF_JUMP: npc = {pc_d_q[31:28], instr_q[25:0], 2'b00};
      CF_JR:   npc = bus.jr_target & ~32'd3;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= PC_RESET;
      instr_q     <= '0;
      pc_d_q      <= PC_RESET;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else if (bus.stall) begin
      if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      instr_q <= fetch_word;
      pc_d_q  <= pc_q;
      valid_q <= 1'b1;
      pc_q    <= npc;
      if (fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign bus.im_addr   = pc_off[IM_AW+1:2];
  assign bus.pc_f      = pc_q;
  assign bus.instr_d   = instr_q;
  assign bus.pc_d      = pc_d_q;
  assign bus.pc8_d     = pc_d_q + 32'd8;
  assign bus.valid_d   = valid_q;
  assign bus.bubble_e  = bus.stall & reset;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fetch_cnt = fetch_cnt_q;
endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed scenarios plus randomized programs against a reference model.
module tb_fetch_decode_stage;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int unsigned IM_AW    = 10;

  logic clk;
  logic reset;
  logic [31:0] rom [0:1023];
  int checks;
  int failures;

  // Reference architectural state
  logic [31:0] m_pc, m_instr, m_pcd, m_sc, m_fc;
  logic        m_valid;

  fetch_decode_stage_if #(.IM_AW(IM_AW)) bus ();

  fetch_decode_stage #(.PC_RESET(PC_RESET), .IM_AW(IM_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb bus.im_rdata = rom[bus.im_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_fetch(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - PC_RESET;
    if (off < 32'd4096) return rom[off / 4];
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_npc(input logic [31:0] instr, input logic [31:0] pcd,
                                          input logic [31:0] pcf, input logic beq,
                                          input logic [31:0] jt);
    int unsigned op, fn;
    int signed off;
    logic [15:0] imm;
    op  = instr / 32'h0400_0000;
    fn  = instr % 64;
    imm = instr[15:0];
    off = $signed(imm);
    if (op == 4 && beq) return pcd + 32'd4 + 32'(off * 4);
    if (op == 2 || op == 3) return (pcd & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4);
    if (op == 0 && fn == 8) return jt & 32'hFFFF_FFFC;
    return pcf + 32'd4;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic drive(input logic rst_n, input logic s, input logic b, input logic [31:0] jt);
    reset = rst_n;
    bus.stall = s;
    bus.br_eq = b;
    bus.jr_target = jt;
    #1;
  endtask

  // Advances both DUT and model by one edge; called from a negedge, returns at the next negedge.
  task automatic clock_edge();
    logic [31:0] n_pc, n_instr, n_pcd, n_sc, n_fc;
    logic n_valid;
    n_pc = m_pc; n_instr = m_instr; n_pcd = m_pcd; n_valid = m_valid; n_sc = m_sc; n_fc = m_fc;
    if (!reset) begin
      n_pc = PC_RESET; n_instr = 0; n_pcd = PC_RESET; n_valid = 0; n_sc = 0; n_fc = 0;
    end else if (bus.stall) begin
      n_sc = sat_inc(m_sc);
    end else begin
      n_instr = ref_fetch(m_pc);
      n_pcd   = m_pc;
      n_valid = 1'b1;
      n_pc    = ref_npc(m_instr, m_pcd, m_pc, bus.br_eq, bus.jr_target);
      n_fc    = sat_inc(m_fc);
    end
    @(posedge clk);
    m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_valid = n_valid; m_sc = n_sc; m_fc = n_fc;
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 32'd0;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    clock_edge();
    clock_edge();
  endtask

  task automatic adv(input logic b, input logic [31:0] jt);
    drive(1'b1, 1'b0, b, jt);
    clock_edge();
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 32'h3401_0005;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'd0);
      checks++; if (bus.bubble_e !== 1'b0) begin failures++; $display("FAIL rst_bubble got=%b exp=0", bus.bubble_e); end
      clock_edge();
    end
    checks++; if (bus.pc_f !== 32'h3000) begin failures++; $display("FAIL rst_pc_f got=%h exp=00003000", bus.pc_f); end
    checks++; if (bus.instr_d !== 32'd0) begin failures++; $display("FAIL rst_instr_d got=%h exp=0", bus.instr_d); end
    checks++; if (bus.pc_d !== 32'h3000) begin failures++; $display("FAIL rst_pc_d got=%h exp=00003000", bus.pc_d); end
    checks++; if (bus.valid_d !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.valid_d); end
    checks++; if (bus.stall_cnt !== 32'd0 || bus.fetch_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%h/%h exp=0/0", bus.stall_cnt, bus.fetch_cnt); end
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    checks++; if (bus.im_addr !== 10'd0) begin failures++; $display("FAIL rel_im_addr got=%h exp=0", bus.im_addr); end
    clock_edge();
    checks++; if (bus.pc_d !== 32'h3000) begin failures++; $display("FAIL rel_pc_d got=%h exp=00003000", bus.pc_d); end
    checks++; if (bus.valid_d !== 1'b1) begin failures++; $display("FAIL rel_valid got=%b exp=1", bus.valid_d); end
    checks++; if (bus.pc_f !== 32'h3004) begin failures++; $display("FAIL rel_pc_f got=%h exp=00003004", bus.pc_f); end
    checks++; if (bus.instr_d !== 32'h3401_0005) begin failures++; $display("FAIL rel_instr_d got=%h exp=34010005", bus.instr_d); end
  endtask

  task automatic test_straight_stall();
    logic [31:0] prog [4];
    prog = '{32'h0022_1821, 32'h3401_0005, 32'h8C02_0000, 32'h0061_2023};
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = prog[i];
    do_reset();
    adv(1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      checks++; if (bus.bubble_e !== 1'b1) begin failures++; $display("FAIL stall_bubble got=%b exp=1", bus.bubble_e); end
      clock_edge();
      checks++; if (bus.pc_f !== 32'h3004 || bus.instr_d !== prog[0]) begin failures++; $display("FAIL stall_hold got=%h/%h exp=00003004/%h", bus.pc_f, bus.instr_d, prog[0]); end
    end
    checks++; if (bus.stall_cnt !== 32'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=2", bus.stall_cnt); end
    for (int i = 1; i < 4; i++) begin
      adv(1'b0, 32'd0);
      checks++; if (bus.instr_d !== prog[i] || bus.pc_d !== 32'h3000 + 32'(4 * i)) begin failures++; $display("FAIL resume_seq%0d got=%h@%h exp=%h@%h", i, bus.instr_d, bus.pc_d, prog[i], 32'h3000 + 32'(4 * i)); end
    end
    checks++; if (bus.fetch_cnt !== 32'd4) begin failures++; $display("FAIL fetch_cnt got=%0d exp=4", bus.fetch_cnt); end
  endtask

  task automatic test_beq();
    for (int t = 0; t < 2; t++) begin
      clear_rom();
      rom[1] = 32'h3401_0001;
      rom[2] = 32'h1000_FFFE;
      rom[3] = 32'h3402_0002;
      do_reset();
      adv(1'b0, 32'd0);
      adv(1'b0, 32'd0);
      adv(1'b0, 32'd0);
      checks++; if (bus.instr_d !== 32'h1000_FFFE || bus.pc_d !== 32'h3008) begin failures++; $display("FAIL beq_in_d got=%h@%h exp=1000fffe@00003008", bus.instr_d, bus.pc_d); end
      adv(t == 0, 32'd0);
      checks++; if (bus.instr_d !== 32'h3402_0002 || bus.pc_d !== 32'h300C) begin failures++; $display("FAIL beq_slot got=%h@%h exp=34020002@0000300c", bus.instr_d, bus.pc_d); end
      checks++; if (bus.pc_f !== ((t == 0) ? 32'h3004 : 32'h3010)) begin failures++; $display("FAIL beq_target%0d got=%h exp=%h", t, bus.pc_f, (t == 0) ? 32'h3004 : 32'h3010); end
    end
  endtask

  task automatic test_jal_jr();
    clear_rom();
    rom[0]  = 32'h0C00_0C10;
    rom[1]  = 32'h3401_0001;
    rom[16] = 32'h03E0_0008;
    rom[17] = 32'h3403_0003;
    do_reset();
    adv(1'b0, 32'd0);
    checks++; if (bus.pc8_d !== 32'h3008) begin failures++; $display("FAIL jal_pc8 got=%h exp=00003008", bus.pc8_d); end
    adv(1'b0, 32'd0);
    checks++; if (bus.pc_f !== 32'h3040 || bus.instr_d !== 32'h3401_0001) begin failures++; $display("FAIL jal_target got=%h/%h exp=00003040/34010001", bus.pc_f, bus.instr_d); end
    adv(1'b0, 32'd0);
    adv(1'b0, 32'h3007);
    checks++; if (bus.pc_f !== 32'h3004 || bus.instr_d !== 32'h3403_0003) begin failures++; $display("FAIL jr_target got=%h/%h exp=00003004/34030003", bus.pc_f, bus.instr_d); end
  endtask

  task automatic test_stall_redirect();
    clear_rom();
    rom[2] = 32'h1000_FFFE;
    do_reset();
    for (int i = 0; i < 3; i++) adv(1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'd0);
    clock_edge();
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    clock_edge();
    checks++; if (bus.pc_f !== 32'h300C || bus.instr_d !== 32'h1000_FFFE) begin failures++; $display("FAIL stall_redir_hold got=%h/%h exp=0000300c/1000fffe", bus.pc_f, bus.instr_d); end
    adv(1'b0, 32'd0);
    checks++; if (bus.pc_f !== 32'h3010) begin failures++; $display("FAIL stall_redir_seq got=%h exp=00003010", bus.pc_f); end
  endtask

  task automatic test_window_wrap();
    clear_rom();
    rom[0] = 32'h0800_1000;
    do_reset();
    adv(1'b0, 32'd0);
    adv(1'b0, 32'd0);
    checks++; if (bus.pc_f !== 32'h4000) begin failures++; $display("FAIL win_pc_f got=%h exp=00004000", bus.pc_f); end
    adv(1'b0, 32'd0);
    checks++; if (bus.instr_d !== 32'd0 || bus.pc_d !== 32'h4000) begin failures++; $display("FAIL win_nop got=%h@%h exp=0@00004000", bus.instr_d, bus.pc_d); end
    clear_rom();
    rom[0] = 32'h03E0_0008;
    do_reset();
    adv(1'b0, 32'd0);
    adv(1'b0, 32'hFFFF_FFFC);
    checks++; if (bus.pc_f !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pre got=%h exp=fffffffc", bus.pc_f); end
    adv(1'b0, 32'd0);
    checks++; if (bus.pc_f !== 32'd0 || bus.instr_d !== 32'd0 || bus.pc_d !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap got=%h/%h/%h exp=0/0/fffffffc", bus.pc_f, bus.instr_d, bus.pc_d); end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int signed off;
    r = $urandom();
    case ($urandom_range(0, 5))
      0, 1: return {6'd0, r[25:6], 6'h21};
      2:    return {6'h0D, r[25:0]};
      3: begin
        off = $signed($urandom_range(0, 32)) - 16;
        return {6'h04, r[25:16], 16'(off)};
      end
      4:    return {5'b00001, r[0], 26'(32'hC00 + $urandom_range(0, 1023))};
      default: return {6'd0, r[25:21], 15'd0, 6'h08};
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] off;
    for (int i = 0; i < 1024; i++) rom[i] = rand_instr();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            32'h3000 + $urandom_range(0, 4095));
      checks++; if (bus.bubble_e !== (bus.stall & reset)) begin failures++; $display("FAIL rnd_bubble c=%0d got=%b exp=%b", c, bus.bubble_e, bus.stall & reset); end
      off = m_pc - PC_RESET;
      if (off < 32'd4096) begin
        checks++; if (bus.im_addr !== off[11:2]) begin failures++; $display("FAIL rnd_im_addr c=%0d got=%h exp=%h", c, bus.im_addr, off[11:2]); end
      end
      clock_edge();
      checks++; if (bus.pc_f !== m_pc || bus.pc_d !== m_pcd || bus.pc8_d !== m_pcd + 32'd8) begin failures++; $display("FAIL rnd_pc c=%0d got=%h/%h/%h exp=%h/%h/%h", c, bus.pc_f, bus.pc_d, bus.pc8_d, m_pc, m_pcd, m_pcd + 32'd8); end
      checks++; if (bus.instr_d !== m_instr || bus.valid_d !== m_valid) begin failures++; $display("FAIL rnd_instr c=%0d got=%h/%b exp=%h/%b", c, bus.instr_d, bus.valid_d, m_instr, m_valid); end
      checks++; if (bus.stall_cnt !== m_sc || bus.fetch_cnt !== m_fc) begin failures++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, bus.stall_cnt, bus.fetch_cnt, m_sc, m_fc); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_pc = PC_RESET; m_instr = 0; m_pcd = PC_RESET; m_valid = 0; m_sc = 0; m_fc = 0;
    clear_rom();
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.br_eq = 1'b0;
    bus.jr_target = 32'd0;
    @(negedge clk);
    test_reset();
    test_straight_stall();
    test_beq();
    test_jal_jr();
    test_stall_redirect();
    test_window_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
